// File: rtl/dsram_responder.sv
`default_nettype none
// ============================================================================
// Module      : dsram_responder
// Description : Word-addressed data memory behind an in-order req/addr_ok,
//               data_ok bus with a bounded queue and a fixed completion latency.
// Revision    : 1.0 - initial release
// ============================================================================
module dsram_responder #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 2,
    parameter int LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_req,
    input  logic                         i_wr,
    input  logic [1:0]                   i_size,
    input  logic [31:0]                  i_addr,
    input  logic [3:0]                   i_wstrb,
    input  logic [31:0]                  i_wdata,
    output logic                         o_addr_ok,
    output logic                         o_data_ok,
    output logic [31:0]                  o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_outstanding
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [31:0]       r_mem   [2**ADDR_W];

    logic              r_vld   [DEPTH];
    logic [CW-1:0]     r_cnt   [DEPTH];
    logic              r_wr    [DEPTH];
    logic [ADDR_W-1:0] r_idx   [DEPTH];
    logic [3:0]        r_strb  [DEPTH];
    logic [31:0]       r_wdata [DEPTH];

    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [OW-1:0]     r_count;

    logic              w_enq;
    logic              w_deq;
    logic              w_unused_bits;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Acceptance looks only at registered occupancy, so a same-cycle dequeue never frees a slot early.
    assign o_addr_ok     = (r_count < OW'(DEPTH));
    assign w_enq         = rstn && i_req && o_addr_ok;
    assign w_deq         = rstn && r_vld[r_head] && (r_cnt[r_head] == '0);
    assign o_data_ok     = w_deq;
    assign o_outstanding = r_count;
    assign o_rdata       = (w_deq && !r_wr[r_head]) ? r_mem[r_idx[r_head]] : 32'h0;

    assign w_unused_bits = ^{i_size, i_addr[31:ADDR_W+2], i_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i] <= 1'b0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
            if (w_deq) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= f_next(r_head);
            end
            // The tail slot is always free here because acceptance requires a non-full queue.
            if (w_enq) begin
                r_vld[r_tail] <= 1'b1;
                r_cnt[r_tail] <= CW'(LATENCY - 1);
                r_tail        <= f_next(r_tail);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_wr[r_tail]    <= i_wr;
            r_idx[r_tail]   <= i_addr[ADDR_W+1:2];
            r_strb[r_tail]  <= i_wstrb;
            r_wdata[r_tail] <= i_wdata;
        end
    end

    // Writes commit only on completion; the dequeue term already excludes reset.
    always_ff @(posedge clk) begin
        if (w_deq && r_wr[r_head]) begin
            for (int b = 0; b < 4; b++) begin
                if (r_strb[r_head][b]) begin
                    r_mem[r_idx[r_head]][8*b +: 8] <= r_wdata[r_head][8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsram_responder
// Description : Scoreboard bench driving three responder instances
//               (latency 2, 4 and 1) over a shared request bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsram_responder;

    logic        clk;
    logic        rstn;
    logic        req [3];
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok [3];
    logic        data_ok [3];
    logic [31:0] rdata [3];
    logic [1:0]  outs [3];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic        wr;
        logic [9:0]  idx;
        logic [3:0]  strb;
        logic [31:0] data;
        int          due;
    } txn_t;

    txn_t        sbq [3][$];
    logic [31:0] mdl [3][1024];
    txn_t        t;

    int lat [3]      = '{2, 4, 1};
    int exp_occ [11] = '{0, 1, 2, 2, 2, 1, 1, 1, 1, 1, 0};
    int exp_aok [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};

    dsram_responder #(.ADDR_W(10), .DEPTH(2), .LATENCY(2)) u_dut0 (
        .clk(clk), .rstn(rstn), .i_req(req[0]), .i_wr(wr), .i_size(size),
        .i_addr(addr), .i_wstrb(wstrb), .i_wdata(wdata), .o_addr_ok(addr_ok[0]),
        .o_data_ok(data_ok[0]), .o_rdata(rdata[0]), .o_outstanding(outs[0]));

    dsram_responder #(.ADDR_W(10), .DEPTH(2), .LATENCY(4)) u_dut1 (
        .clk(clk), .rstn(rstn), .i_req(req[1]), .i_wr(wr), .i_size(size),
        .i_addr(addr), .i_wstrb(wstrb), .i_wdata(wdata), .o_addr_ok(addr_ok[1]),
        .o_data_ok(data_ok[1]), .o_rdata(rdata[1]), .o_outstanding(outs[1]));

    dsram_responder #(.ADDR_W(10), .DEPTH(2), .LATENCY(1)) u_dut2 (
        .clk(clk), .rstn(rstn), .i_req(req[2]), .i_wr(wr), .i_size(size),
        .i_addr(addr), .i_wstrb(wstrb), .i_wdata(wdata), .o_addr_ok(addr_ok[2]),
        .o_data_ok(data_ok[2]), .o_rdata(rdata[2]), .o_outstanding(outs[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model: writes are applied in completion order, reads compared against it.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rstn) begin
                sbq[d].delete();
                chk("rst_data_ok", {31'b0, data_ok[d]}, 32'h0);
            end else begin
                if (data_ok[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk("spurious_data_ok", 32'h1, 32'h0);
                    end else begin
                        t = sbq[d].pop_front();
                        chk("data_ok_cycle", cyc, t.due);
                        if (t.wr) begin
                            chk("wr_rdata_zero", rdata[d], 32'h0);
                            for (int b = 0; b < 4; b++)
                                if (t.strb[b]) mdl[d][t.idx][8*b +: 8] = t.data[8*b +: 8];
                        end else begin
                            chk("rd_data", rdata[d], mdl[d][t.idx]);
                        end
                    end
                end else begin
                    chk("idle_rdata_zero", rdata[d], 32'h0);
                    if (sbq[d].size() > 0 && cyc > sbq[d][0].due) begin
                        chk("missing_data_ok", cyc, sbq[d][0].due);
                        void'(sbq[d].pop_front());
                    end
                end
                if (req[d] && addr_ok[d])
                    sbq[d].push_back('{wr, addr[11:2], wstrb, wdata, cyc + lat[d]});
            end
        end
    end

    task automatic issue(input int d, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] v);
        int n;
        @(posedge clk);
        #1;
        req[d] = 1'b1; wr = w; addr = a; wstrb = s; wdata = v;
        n = 0;
        forever begin
            @(negedge clk);
            if (addr_ok[d]) break;
            n++;
            if (n > 50) begin
                chk("issue_timeout", 32'h0, 32'h1);
                break;
            end
        end
    endtask

    task automatic idle(input int d, input int cycles);
        @(posedge clk);
        #1;
        req[d] = 1'b0;
        repeat (cycles) @(posedge clk);
    endtask

    initial begin
        int acc;
        rstn = 1'b0; wr = 1'b0; size = 2'd2; addr = '0; wstrb = '0; wdata = '0;
        for (int d = 0; d < 3; d++) req[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_addr_ok", {31'b0, addr_ok[d]}, 32'h1);
            chk("rst_outstanding", {30'b0, outs[d]}, 32'h0);
            chk("rst_rdata", rdata[d], 32'h0);
        end

        // Write then read, latency 2
        issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0);
        idle(0, 6);

        // Partial strobe and zero-strobe write
        issue(0, 1'b1, 32'h80, 4'hF, 32'h11223344);
        issue(0, 1'b1, 32'h80, 4'b0100, 32'h00AA0000);
        issue(0, 1'b0, 32'h80, 4'h0, 32'h0);
        issue(0, 1'b1, 32'h80, 4'h0, 32'hFFFFFFFF);
        issue(0, 1'b0, 32'h80, 4'h0, 32'h0);
        idle(0, 6);

        // Full queue with req held, latency 4
        for (int i = 0; i < 3; i++) issue(1, 1'b1, 32'h100 + 4*i, 4'hF, 32'hC0DE0000 + i);
        idle(1, 10);
        acc = 0;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk);
            #1;
            req[1] = (acc < 3); wr = 1'b0; addr = 32'h100 + 4*acc; wstrb = 4'h0;
            @(negedge clk);
            chk("full_outstanding", {30'b0, outs[1]}, exp_occ[k]);
            chk("full_addr_ok", {31'b0, addr_ok[1]}, exp_aok[k]);
            if (req[1] && addr_ok[1]) acc++;
        end
        idle(1, 6);

        // Back-to-back reads, latency 1
        for (int i = 0; i < 4; i++) issue(2, 1'b1, 4*i, 4'hF, 32'hA5A50000 + 32'(i * 17));
        idle(2, 4);
        for (int i = 0; i < 4; i++) begin
            issue(2, 1'b0, 4*i, 4'h0, 32'h0);
            if (i > 0) chk("b2b_outstanding", {30'b0, outs[2]}, 32'h1);
        end
        idle(2, 4);

        // Reset while a write is in flight
        issue(0, 1'b1, 32'h40, 4'hF, 32'h0);
        idle(0, 4);
        issue(0, 1'b1, 32'h40, 4'hF, 32'h55);
        @(posedge clk);
        #1 req[0] = 1'b0; rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("midrst_outstanding", {30'b0, outs[0]}, 32'h0);
        repeat (4) @(posedge clk);
        issue(0, 1'b0, 32'h40, 4'h0, 32'h0);
        idle(0, 4);

        // Address aliasing on the word index
        issue(0, 1'b1, 32'h1000, 4'hF, 32'h1234);
        issue(0, 1'b0, 32'h0000, 4'h0, 32'h0);
        issue(0, 1'b0, 32'h0003, 4'h0, 32'h0);
        idle(0, 8);

        for (int d = 0; d < 3; d++) chk("drained", sbq[d].size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsram_responder.md
Name: dsram_responder

Overview:
- Memory-side responder for the core's data SRAM-like bus. It serves the requests that the Execute stage issues; the Memory stage consumes the resulting rdata.
- Holds a word-addressed data array and accepts in-order read/write requests through a req/addr_ok address handshake.
- Completes each accepted request with a one-cycle data_ok pulse a fixed LATENCY later. A bounded queue holds outstanding requests.
- Used as the data memory in core-level simulation and as the reference slave for load/store verification.

Parameters:
- ADDR_W, 10, word-index width; array holds 2^ADDR_W 32-bit words.
- DEPTH, 2, maximum outstanding accepted-but-uncompleted requests (>=1).
- LATENCY, 2, cycles from address handshake to data_ok (>=1).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req  in  1  request valid from core
- wr  in  1  1 = write, 0 = read
- size  in  2  access size (0 byte, 1 half, 2 word); carried for bus completeness, not used by the array
- addr  in  32  byte address; word index = addr[ADDR_W+1:2]; addr[1:0] and upper bits ignored
- wstrb  in  4  byte write enables, valid when wr=1
- wdata  in  32  write data, byte lanes pre-aligned by core
- addr_ok  out  1  request accepted this cycle when req && addr_ok
- data_ok  out  1  one-cycle completion pulse for queue head
- rdata  out  32  full read word, valid when data_ok for a read
- outstanding  out  $clog2(DEPTH+1)  current queue occupancy

Behaviour:
- Clocking and reset:
  - Reset rstn, synchronous, active-low; clock clk.
  - Reset empties the queue, sets occupancy to 0 and clears all entry countdowns.
  - The memory array is NOT reset.
- Output values during and after reset:
  - data_ok=0, outstanding=0, rdata=0.
  - addr_ok=1 in the first cycle after reset.
- Acceptance:
  - addr_ok = (outstanding < DEPTH), combinational from registered occupancy only.
  - A dequeue in the same cycle does not raise addr_ok (no full-queue bypass).
  - A handshake (req && addr_ok) at cycle T enqueues {wr, word index, wstrb, wdata} at the tail, with countdown = LATENCY-1.
- Countdown: each cycle every valid entry whose countdown > 0 decrements by 1.
- Completion:
  - data_ok = head valid && head countdown == 0. The head dequeues in the same cycle.
  - A request accepted at cycle T gets data_ok exactly at cycle T+LATENCY.
  - Back-to-back accepts give back-to-back data_ok pulses, strictly in acceptance order.
- Read completion: rdata = mem[index] combinationally during the data_ok cycle. rdata = 0 whenever data_ok=0.
- Write completion:
  - At the clock edge ending the data_ok cycle, byte lane i of mem[index] takes wdata[8i+7:8i] when wstrb[i]=1; other lanes are unchanged.
  - rdata = 0 on write completion.
  - wstrb = 0 is a legal write that changes nothing.
- Ordering:
  - Writes commit at completion, so a read queued after a write to the same word returns the written data.
  - A read completing in the same cycle a write commits returns the pre-write value. This only occurs for distinct-queue-position entries, which is impossible given in-order single dequeue.
- Occupancy: enqueue and dequeue in the same cycle leave outstanding unchanged. Enqueue alone increments it; dequeue alone decrements it.
- Queue storage: circular buffer; head/tail pointers wrap modulo DEPTH.
- Requests during full: req held while addr_ok=0 is not accepted. The core must hold req/addr/wr/wstrb/wdata stable until the handshake; the responder samples only on handshake.
- Reset mid-operation: outstanding requests are dropped, no data_ok is ever produced for them, and pending writes are not committed.
- No backpressure on data_ok; the consumer must always accept.

Test Plan:
1. Reset, LATENCY=2. Write addr=0x10, wstrb=4'hF, wdata=0xDEADBEEF at cycle 5, then read addr=0x10 at cycle 7 -> addr_ok=1 both, data_ok at 7 and 9, rdata=0xDEADBEEF at cycle 9, rdata=0 at cycle 7.
2. Partial strobe: word 0x20 holds 0x11223344; write wstrb=4'b0100, wdata=0x00AA0000; read back -> rdata=0x11AA3344.
3. Full queue, DEPTH=2, LATENCY=4. req held high with 3 reads at cycles 0,1,2 -> accepts at 0,1; addr_ok=0 at 2-4, 1 at 5; third accepted at 5; data_ok at 4, 5 and 9; outstanding sequence 0,1,2,2,2,1,...
4. Back-to-back, LATENCY=1. Reads of words 0..3 on consecutive cycles -> data_ok every cycle, returned in order, outstanding stays 1.
5. Reset mid-flight. Accept write 0x55 to 0x40 (word previously 0x0) and assert rstn=0 before its data_ok -> no data_ok; a later read of 0x40 returns 0x0.
6. Address aliasing, ADDR_W=10. Write 0x1234 to addr 0x1000, read addr 0x0000 -> 0x1234; read addr 0x0003 -> same word.
